// File: rtl/sdspi_pkg.sv
// Shared command encodings, FSM state type and init-sequence constants for the SD SPI controller.
package sdspi_pkg;

  localparam int unsigned CMD_W       = 2;
  localparam int unsigned INIT_CLOCKS = 80;

  localparam logic [CMD_W-1:0] CMD_DESEL = 2'd0;
  localparam logic [CMD_W-1:0] CMD_INIT  = 2'd1;
  localparam logic [CMD_W-1:0] CMD_XFER  = 2'd2;
  localparam logic [CMD_W-1:0] CMD_SEL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CSOP    = 3'd1,
    INIT    = 3'd2,
    XFER_LO = 3'd3,
    XFER_HI = 3'd4
  } state_t;

endpackage

// File: rtl/sdspi_sync.sv
// Two-flop synchronizer for the card's MISO line; idles high like an undriven SD data line.
module sdspi_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdspi_ctrl.sv
// SD-card SPI byte engine: chip-select ops, 80-clock init sequence and mode-0 byte transfers.
module sdspi_ctrl
  import sdspi_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned FF_LIMIT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CMD_W-1:0] sd_cmd,
  input  logic [7:0]       sd_out,
  input  logic             sd_signal,
  output logic [7:0]       sd_din,
  output logic             sd_busy,
  output logic             sd_timeout,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned INIT_W = 7;

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLOCKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
  localparam logic [7:0]        FF_MAX    = 8'(FF_LIMIT);

  state_t            state, state_d;
  logic [CNT_W-1:0]  div_cnt, div_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [INIT_W-1:0] init_cnt, init_d;
  logic [7:0]        tx_sr, tx_d;
  logic [7:0]        rx_sr, rx_d;
  logic [7:0]        ff_count, ff_d;
  logic [7:0]        din_d;
  logic              busy_d, timeout_d, cs_d, sclk_d, mosi_d;
  logic              sig_q;
  logic              miso_s;
  logic              launch_c;
  logic [7:0]        rx_next_c;

  sdspi_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (spi_miso),
    .q     (miso_s)
  );

  assign launch_c  = sd_signal & ~sig_q;
  assign rx_next_c = {rx_sr[6:0], miso_s};

  // State, counters, shift registers and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      init_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      ff_count   <= '0;
      sig_q      <= 1'b0;
      sd_din     <= 8'hFF;
      sd_busy    <= 1'b0;
      sd_timeout <= 1'b0;
      spi_cs     <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b1;
    end else begin
      state      <= state_d;
      div_cnt    <= div_d;
      bit_cnt    <= bit_d;
      init_cnt   <= init_d;
      tx_sr      <= tx_d;
      rx_sr      <= rx_d;
      ff_count   <= ff_d;
      sig_q      <= sd_signal;
      sd_din     <= din_d;
      sd_busy    <= busy_d;
      sd_timeout <= timeout_d;
      spi_cs     <= cs_d;
      spi_sclk   <= sclk_d;
      spi_mosi   <= mosi_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    init_d  = init_cnt;
    tx_d    = tx_sr;
    rx_d    = rx_sr;
    ff_d    = ff_count;
    din_d   = sd_din;
    cs_d    = spi_cs;
    sclk_d  = spi_sclk;
    mosi_d  = spi_mosi;

    unique case (state)
      IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b1;
        div_d  = '0;
        bit_d  = '0;
        init_d = '0;
        if (launch_c) begin
          unique case (sd_cmd)
            CMD_DESEL: begin
              state_d = CSOP;
              cs_d    = 1'b1;
              ff_d    = '0;
            end
            CMD_SEL: begin
              state_d = CSOP;
              cs_d    = 1'b0;
              ff_d    = '0;
            end
            CMD_INIT: begin
              state_d = INIT;
              cs_d    = 1'b1;
              ff_d    = '0;
            end
            default: begin
              state_d = XFER_LO;
              tx_d    = sd_out;
              mosi_d  = sd_out[7];
              rx_d    = '0;
            end
          endcase
        end
      end

      CSOP: state_d = IDLE;

      // Free-running SCLK with CS and MOSI held high; a period ends on the high-phase wrap.
      INIT: begin
        if (div_cnt == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~spi_sclk;
          if (spi_sclk) begin
            if (init_cnt == INIT_LAST) begin
              state_d = IDLE;
              init_d  = '0;
            end else begin
              init_d = init_cnt + 7'd1;
            end
          end
        end else begin
          div_d = div_cnt + 8'd1;
        end
      end

      XFER_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = XFER_HI;
        end else begin
          div_d = div_cnt + 8'd1;
        end
      end

      // Sample MISO late in the high phase, then either present the next bit or finish the byte.
      XFER_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          rx_d   = rx_next_c;
          if (bit_cnt == BIT_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            mosi_d  = 1'b1;
            din_d   = rx_next_c;
            if (rx_next_c == 8'hFF) begin
              ff_d = (ff_count == FF_MAX) ? ff_count : ff_count + 8'd1;
            end else begin
              ff_d = '0;
            end
          end else begin
            state_d = XFER_LO;
            bit_d   = bit_cnt + 3'd1;
            mosi_d  = tx_sr[6];
            tx_d    = {tx_sr[6:0], 1'b0};
          end
        end else begin
          div_d = div_cnt + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    timeout_d = (ff_d == FF_MAX);
  end

endmodule
